// File: rtl/display_scan_driver.sv
// ---------------------------------------------------------------------------
// display_scan_driver
//
// Purpose:
//   Drives a 4-digit common-anode 7-segment display from the stopwatch's
//   16-bit packed BCD time bus. One digit is lit at a time, and the scan
//   moves to the next digit every REFRESH_DIV clock cycles.
//   Digit 3 = minutes, 2 = tens of seconds, 1 = seconds, 0 = tenths.
//   A shadow copy of the digits is taken once per frame, so a frame never
//   mixes an old value with a new one. A freeze input holds the shown value
//   for lap display. Leading zeros are blanked and a fixed decimal-point
//   mask is applied.
//
// Ports:
//   clock    in   1   system clock, everything on the rising edge
//   reset    in   1   synchronous, active-high
//   digits   in  16   {d3,d2,d1,d0} packed BCD from the time counter
//   freeze   in   1   1 = keep the currently shown value (lap hold)
//   blank    in   1   1 = display dark while the scan keeps running
//   segment  out  7   active-low {g,f,e,d,c,b,a}
//   dp       out  1   active-low decimal point
//   anode    out  4   active-low digit enables, one-cold while displaying
// ---------------------------------------------------------------------------
module display_scan_driver #(
  parameter int         REFRESH_DIV = 100000,
  parameter int         MIN_DIGITS  = 2,
  parameter logic [3:0] DP_MASK     = 4'b0010
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [15:0] digits,
  input  logic        freeze,
  input  logic        blank,
  output logic [6:0]  segment,
  output logic        dp,
  output logic [3:0]  anode
);

  localparam int            PW   = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [PW-1:0] PMAX = PW'(REFRESH_DIV - 1);

  logic [PW-1:0] r_presc;
  logic [1:0]    r_idx;
  logic [15:0]   r_shadow;

  logic          w_tick;
  logic [3:0]    w_digit;
  logic [6:0]    w_pattern;
  logic [3:0]    w_posBlank;
  logic          w_zeroRun;
  logic [3:0]    w_anodeNext;
  logic [6:0]    w_segNext;
  logic          w_dpNext;

  assign w_tick = (r_presc == PMAX);

  // Slot prescaler: counts 0..REFRESH_DIV-1 and wraps, producing one tick
  // on the last count of every digit slot.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_presc <= '0;
    end else if (w_tick) begin
      r_presc <= '0;
    end else begin
      r_presc <= r_presc + PW'(1);
    end
  end

  // Scan index and per-frame shadow latch. The shadow only loads on the
  // tick that wraps the index from 3 back to 0, so a frame always shows one
  // consistent snapshot. Freeze just suppresses that load.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_idx    <= 2'd0;
      r_shadow <= 16'h0000;
    end else if (w_tick) begin
      r_idx <= r_idx + 2'd1;
      if ((r_idx == 2'd3) && !freeze) begin
        r_shadow <= digits;
      end
    end
  end

  // Leading-zero detection: walk from the most significant digit downwards
  // while every digit seen so far is zero. Only positions at or above
  // MIN_DIGITS may be blanked, so the low digits always show "0".
  always_comb begin
    w_zeroRun  = 1'b1;
    w_posBlank = 4'b0000;
    for (int i = 3; i >= 0; i--) begin
      w_zeroRun = w_zeroRun && (r_shadow[i*4 +: 4] == 4'd0);
      if (i >= MIN_DIGITS) begin
        w_posBlank[i] = w_zeroRun;
      end
    end
  end

  // BCD to active-low segment decode of the digit in the current slot.
  // Codes 10-15 are not valid BCD and show a lone dash (segment g).
  always_comb begin
    w_digit = r_shadow[{r_idx, 2'b00} +: 4];
    case (w_digit)
      4'd0:    w_pattern = 7'b1000000;
      4'd1:    w_pattern = 7'b1111001;
      4'd2:    w_pattern = 7'b0100100;
      4'd3:    w_pattern = 7'b0110000;
      4'd4:    w_pattern = 7'b0011001;
      4'd5:    w_pattern = 7'b0010010;
      4'd6:    w_pattern = 7'b0000010;
      4'd7:    w_pattern = 7'b1111000;
      4'd8:    w_pattern = 7'b0000000;
      4'd9:    w_pattern = 7'b0010000;
      default: w_pattern = 7'b0111111;
    endcase
  end

  // Next output values. Blank wins over everything and a zero-blanked
  // position goes fully dark, including its decimal point.
  always_comb begin
    w_anodeNext = 4'hF;
    w_segNext   = 7'h7F;
    w_dpNext    = 1'b1;
    if (!blank && !w_posBlank[r_idx]) begin
      w_anodeNext = ~(4'b0001 << r_idx);
      w_segNext   = w_pattern;
      w_dpNext    = ~DP_MASK[r_idx];
    end
  end

  // Registered outputs. Anode and segment update on the same edge, so the
  // previous digit's pattern never appears on the next digit.
  always_ff @(posedge clock) begin
    if (reset) begin
      anode   <= 4'hF;
      segment <= 7'h7F;
      dp      <= 1'b1;
    end else begin
      anode   <= w_anodeNext;
      segment <= w_segNext;
      dp      <= w_dpNext;
    end
  end

endmodule

// File: tb/tb_display_scan_driver.sv
// ---------------------------------------------------------------------------
// tb_display_scan_driver
//
// Purpose:
//   Directed bench for display_scan_driver with REFRESH_DIV=4, MIN_DIGITS=2
//   and DP_MASK=4'b0010. Outputs are sampled on the falling clock edge. Each
//   expected value is the triple {anode, segment, dp} worked out by hand.
// ---------------------------------------------------------------------------
module tb_display_scan_driver;

  logic        clock;
  logic        reset;
  logic [15:0] digits;
  logic        freeze;
  logic        blank;
  logic [6:0]  segment;
  logic        dp;
  logic [3:0]  anode;

  int compared;
  int mismatched;

  display_scan_driver #(
    .REFRESH_DIV(4),
    .MIN_DIGITS (2),
    .DP_MASK    (4'b0010)
  ) dut (
    .clock  (clock),
    .reset  (reset),
    .digits (digits),
    .freeze (freeze),
    .blank  (blank),
    .segment(segment),
    .dp     (dp),
    .anode  (anode)
  );

  // 100 MHz-style clock, 10 time units per period.
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // Advance to the first cycle of the next frame. That is the first falling
  // edge on which anode newly reads 1110. Slot 0 is never zero-blanked, so
  // this edge always arrives unless the scan is broken.
  task automatic waitFrameStart();
    logic [3:0] prev;
    int         n;
    prev = anode;
    for (n = 0; n < 40; n++) begin
      @(negedge clock);
      if ((anode == 4'b1110) && (prev != 4'b1110)) break;
      prev = anode;
    end
    if (n == 40) begin
      compared++;
      mismatched++;
      $display("[TB] FAIL frameStart: anode=%b never re-entered 1110 within 40 cycles", anode);
    end
  endtask

  // Reset held for three cycles gives the dark idle outputs.
  task automatic test_reset();
    reset  = 1'b1;
    digits = 16'h1234;
    freeze = 1'b0;
    blank  = 1'b0;
    repeat (3) @(negedge clock);
    compared++;
    if ({anode, segment, dp} !== {4'hF, 7'h7F, 1'b1}) begin
      mismatched++;
      $display("[TB] FAIL reset: got %b/%b/%b want 1111/1111111/1", anode, segment, dp);
    end
    reset = 1'b0;
  endtask

  // The first frame shows the cleared shadow, with slots 2 and 3 zero-blanked.
  // The second frame shows 1234 and the dp is on the seconds digit only.
  task automatic test_scan_decode();
    logic [11:0] exp [8];
    exp[0] = {4'b1110, 7'b1000000, 1'b1};
    exp[1] = {4'b1101, 7'b1000000, 1'b0};
    exp[2] = {4'b1111, 7'b1111111, 1'b1};
    exp[3] = {4'b1111, 7'b1111111, 1'b1};
    exp[4] = {4'b1110, 7'b0011001, 1'b1};
    exp[5] = {4'b1101, 7'b0110000, 1'b0};
    exp[6] = {4'b1011, 7'b0100100, 1'b1};
    exp[7] = {4'b0111, 7'b1111001, 1'b1};
    for (int k = 0; k < 8; k++) begin
      if (k == 0) @(negedge clock);
      else repeat (4) @(negedge clock);
      compared++;
      if ({anode, segment, dp} !== exp[k]) begin
        mismatched++;
        $display("[TB] FAIL scan_decode slot%0d: got %b want %b", k, {anode, segment, dp}, exp[k]);
      end
    end
  endtask

  // With 0005, the two upper digits blank and the seconds digit still shows 0.
  task automatic test_zero_blank();
    logic [11:0] exp [4];
    exp[0] = {4'b1110, 7'b0010010, 1'b1};
    exp[1] = {4'b1101, 7'b1000000, 1'b0};
    exp[2] = {4'b1111, 7'b1111111, 1'b1};
    exp[3] = {4'b1111, 7'b1111111, 1'b1};
    digits = 16'h0005;
    waitFrameStart();
    for (int k = 0; k < 4; k++) begin
      if (k != 0) repeat (4) @(negedge clock);
      compared++;
      if ({anode, segment, dp} !== exp[k]) begin
        mismatched++;
        $display("[TB] FAIL zero_blank slot%0d: got %b want %b", k, {anode, segment, dp}, exp[k]);
      end
    end
  endtask

  // Digits change to 5678 during slot 1. The rest of the frame still shows
  // 1234, and the whole next frame shows 5678.
  task automatic test_midframe_update();
    logic [11:0] exp [8];
    exp[0] = {4'b1110, 7'b0011001, 1'b1};
    exp[1] = {4'b1101, 7'b0110000, 1'b0};
    exp[2] = {4'b1011, 7'b0100100, 1'b1};
    exp[3] = {4'b0111, 7'b1111001, 1'b1};
    exp[4] = {4'b1110, 7'b0000000, 1'b1};
    exp[5] = {4'b1101, 7'b1111000, 1'b0};
    exp[6] = {4'b1011, 7'b0000010, 1'b1};
    exp[7] = {4'b0111, 7'b0010010, 1'b1};
    digits = 16'h1234;
    waitFrameStart();
    for (int k = 0; k < 8; k++) begin
      if (k != 0) repeat (4) @(negedge clock);
      if (k == 1) digits = 16'h5678;
      compared++;
      if ({anode, segment, dp} !== exp[k]) begin
        mismatched++;
        $display("[TB] FAIL midframe slot%0d: got %b want %b", k, {anode, segment, dp}, exp[k]);
      end
    end
  endtask

  // Freeze holds 5678 while the digits ramp over three frames. Freeze is
  // released mid-frame; the new digits (0913) appear only in the next frame.
  task automatic test_freeze();
    logic [15:0] ramp [3];
    logic [11:0] exp [4];
    ramp[0] = 16'h1230;
    ramp[1] = 16'h4561;
    ramp[2] = 16'h7892;
    freeze  = 1'b1;
    for (int k = 0; k < 3; k++) begin
      digits = ramp[k];
      waitFrameStart();
      compared++;
      if ({anode, segment, dp} !== {4'b1110, 7'b0000000, 1'b1}) begin
        mismatched++;
        $display("[TB] FAIL freeze_hold%0d slot0: got %b/%b/%b want 1110/0000000/1", k, anode, segment, dp);
      end
      repeat (12) @(negedge clock);
      compared++;
      if ({anode, segment, dp} !== {4'b0111, 7'b0010010, 1'b1}) begin
        mismatched++;
        $display("[TB] FAIL freeze_hold%0d slot3: got %b/%b/%b want 0111/0010010/1", k, anode, segment, dp);
      end
    end
    waitFrameStart();
    repeat (4) @(negedge clock);
    freeze = 1'b0;
    digits = 16'h0913;
    compared++;
    if ({anode, segment, dp} !== {4'b1101, 7'b1111000, 1'b0}) begin
      mismatched++;
      $display("[TB] FAIL freeze_release slot1: got %b/%b/%b want 1101/1111000/0", anode, segment, dp);
    end
    repeat (4) @(negedge clock);
    compared++;
    if ({anode, segment, dp} !== {4'b1011, 7'b0000010, 1'b1}) begin
      mismatched++;
      $display("[TB] FAIL freeze_release slot2: got %b/%b/%b want 1011/0000010/1", anode, segment, dp);
    end
    exp[0] = {4'b1110, 7'b0110000, 1'b1};
    exp[1] = {4'b1101, 7'b1111001, 1'b0};
    exp[2] = {4'b1011, 7'b0010000, 1'b1};
    exp[3] = {4'b1111, 7'b1111111, 1'b1};
    waitFrameStart();
    for (int k = 0; k < 4; k++) begin
      if (k != 0) repeat (4) @(negedge clock);
      compared++;
      if ({anode, segment, dp} !== exp[k]) begin
        mismatched++;
        $display("[TB] FAIL unfrozen slot%0d: got %b want %b", k, {anode, segment, dp}, exp[k]);
      end
    end
  endtask

  // Illegal BCD shows a dash. Blank applied mid-slot darkens the display on
  // the next cycle without disturbing the cadence. Reset applied mid-slot
  // clears the outputs, and the first tick comes 4 cycles after release.
  task automatic test_dash_blank_reset();
    digits = 16'h00C0;
    waitFrameStart();
    compared++;
    if ({anode, segment, dp} !== {4'b1110, 7'b1000000, 1'b1}) begin
      mismatched++;
      $display("[TB] FAIL dash slot0: got %b/%b/%b want 1110/1000000/1", anode, segment, dp);
    end
    blank = 1'b1;
    @(negedge clock);
    compared++;
    if ({anode, segment, dp} !== {4'b1111, 7'b1111111, 1'b1}) begin
      mismatched++;
      $display("[TB] FAIL blank_dark: got %b/%b/%b want 1111/1111111/1", anode, segment, dp);
    end
    repeat (2) @(negedge clock);
    blank = 1'b0;
    @(negedge clock);
    compared++;
    if ({anode, segment, dp} !== {4'b1101, 7'b0111111, 1'b0}) begin
      mismatched++;
      $display("[TB] FAIL dash slot1 after blank: got %b/%b/%b want 1101/0111111/0", anode, segment, dp);
    end
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    compared++;
    if ({anode, segment, dp} !== {4'b1111, 7'b1111111, 1'b1}) begin
      mismatched++;
      $display("[TB] FAIL midslot_reset: got %b/%b/%b want 1111/1111111/1", anode, segment, dp);
    end
    reset = 1'b0;
    @(negedge clock);
    compared++;
    if ({anode, segment, dp} !== {4'b1110, 7'b1000000, 1'b1}) begin
      mismatched++;
      $display("[TB] FAIL post_reset slot0: got %b/%b/%b want 1110/1000000/1", anode, segment, dp);
    end
    repeat (3) @(negedge clock);
    compared++;
    if ({anode, segment, dp} !== {4'b1110, 7'b1000000, 1'b1}) begin
      mismatched++;
      $display("[TB] FAIL post_reset slot0 last cycle: got %b/%b/%b want 1110/1000000/1", anode, segment, dp);
    end
    @(negedge clock);
    compared++;
    if ({anode, segment, dp} !== {4'b1101, 7'b1000000, 1'b0}) begin
      mismatched++;
      $display("[TB] FAIL post_reset slot1: got %b/%b/%b want 1101/1000000/0", anode, segment, dp);
    end
  endtask

  // Run the scenarios in order. Each one picks up the scan where the
  // previous scenario left it.
  initial begin
    compared   = 0;
    mismatched = 0;
    test_reset();
    test_scan_decode();
    test_zero_blank();
    test_midframe_update();
    test_freeze();
    test_dash_blank_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
